// File: rtl/csa_accumulator.sv
// Multi-operand carry-save accumulator.
// Each accepted beat folds LANES operands into a redundant (sum, carry) state
// through a chain of 3:2 compressors, with no carry propagation per beat.
// A single carry-propagate add resolves the packet total after the last beat.
module csa_accumulator #(
    parameter int WIDTH     = 32,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 40,
    parameter bit SIGNED    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_mask,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_sum,
    output logic [15:0]            out_beats
);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [ACC_WIDTH-1:0]   s_reg;
    logic [ACC_WIDTH-1:0]   c_reg;
    logic [15:0]            count_reg;
    logic [ACC_WIDTH-1:0]   out_sum_reg;
    logic [15:0]            out_beats_reg;
    logic                   out_valid_reg;

    logic [ACC_WIDTH-1:0]   lane_ext [LANES];
    logic [ACC_WIDTH-1:0]   s_next;
    logic [ACC_WIDTH-1:0]   c_next;

    // Masked lanes contribute zero; live lanes are widened to the accumulator
    // width, replicating the sign bit when operands are two's complement.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] lane_raw;
        assign lane_raw = in_data[gi*WIDTH +: WIDTH];
        if (SIGNED) begin : g_sext
            assign lane_ext[gi] = in_mask[gi] ? ACC_WIDTH'($signed(lane_raw)) : '0;
        end else begin : g_zext
            assign lane_ext[gi] = in_mask[gi] ? ACC_WIDTH'(lane_raw) : '0;
        end
    end

    // Carry-save reduction: starting from the stored (S, C) pair, each lane is
    // absorbed by one 3:2 layer. The carry is weighted (shifted left) before
    // the next layer, so the MSB carry falls off, giving mod 2^ACC_WIDTH wrap.
    always_comb begin
        logic [ACC_WIDTH-1:0] s_t;
        logic [ACC_WIDTH-1:0] c_t;
        logic [ACC_WIDTH-1:0] x_t;
        s_t = s_reg;
        c_t = c_reg;
        x_t = '0;
        for (int k = 0; k < LANES; k++) begin
            x_t = lane_ext[k];
            {s_t, c_t} = {s_t ^ c_t ^ x_t,
                          ((s_t & c_t) | (s_t & x_t) | (c_t & x_t)) << 1};
        end
        s_next = s_t;
        c_next = c_t;
    end

    // Ready depends only on state and reset, never on in_valid or out_ready.
    assign in_ready  = !rst && (state_reg == ACCUM);
    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_beats = out_beats_reg;

    // Packet FSM: accumulate beats, resolve once, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACCUM;
            s_reg         <= '0;
            c_reg         <= '0;
            count_reg     <= '0;
            out_sum_reg   <= '0;
            out_beats_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (in_valid) begin
                        s_reg <= s_next;
                        c_reg <= c_next;
                        if (count_reg != 16'hFFFF) begin
                            count_reg <= count_reg + 16'd1;
                        end
                        if (in_last) begin
                            state_reg <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    out_sum_reg   <= s_reg + c_reg;
                    out_beats_reg <= count_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        s_reg         <= '0;
                        c_reg         <= '0;
                        count_reg     <= '0;
                        state_reg     <= ACCUM;
                    end
                end
                default: begin
                    state_reg <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: a signed 40-bit instance and an unsigned 32-bit
// instance share one input stream; each is compared with an arithmetic model.
module tb_csa_accumulator;

    localparam int W = 32;
    localparam int L = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_last;
    logic           out_ready;
    logic [L*W-1:0] in_data;
    logic [L-1:0]   in_mask;

    logic           in_ready_a, out_valid_a;
    logic [39:0]    out_sum_a;
    logic [15:0]    out_beats_a;
    logic           in_ready_b, out_valid_b;
    logic [31:0]    out_sum_b;
    logic [15:0]    out_beats_b;

    int errors = 0;
    int checks = 0;

    // Reference: plain running sums and a beat count for the current packet.
    logic [39:0] exp_a;
    logic [31:0] exp_b;
    int          exp_beats;

    always #5 clk = ~clk;

    csa_accumulator #(.WIDTH(W), .LANES(L), .ACC_WIDTH(40), .SIGNED(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .out_beats(out_beats_a)
    );

    csa_accumulator #(.WIDTH(W), .LANES(L), .ACC_WIDTH(32), .SIGNED(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_mask(in_mask), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .out_beats(out_beats_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_a     = '0;
        exp_b     = '0;
        exp_beats = 0;
    endtask

    // Compare the redundant state of both instances with the model total.
    task automatic check_running(input string tag);
        logic [39:0] sc_a;
        logic [31:0] sc_b;
        sc_a = u_dut.s_reg + u_dut.c_reg;
        sc_b = u_wrap.s_reg + u_wrap.c_reg;
        check({tag, "_a"}, sc_a, exp_a);
        check({tag, "_b"}, sc_b, exp_b);
    endtask

    // Present one beat at a negedge; it is taken at the next posedge.
    task automatic push_beat(input logic [L*W-1:0] data, input logic [L-1:0] mask,
                             input logic last);
        int n;
        logic [W-1:0] lane;
        in_data  = data;
        in_mask  = mask;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_a", in_ready_a, 1'b1);
        check("in_ready_b", in_ready_b, 1'b1);
        for (int k = 0; k < L; k++) begin
            lane = data[k*W +: W];
            if (mask[k]) begin
                exp_a = exp_a + {{8{lane[W-1]}}, lane};
                exp_b = exp_b + lane;
            end
        end
        if (exp_beats < 16'hFFFF) exp_beats++;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_running("running");
        if (last) check("resolve_gap", out_valid_a, 1'b0);
        $display("beat data=%h mask=%b last=%0b run_a=%h run_b=%h", data, mask, last, exp_a, exp_b);
    endtask

    // Expect the result one cycle after RESOLVE, stall `hold` cycles with
    // fresh input offered, then complete the handshake.
    task automatic collect(input int hold);
        @(negedge clk);
        check("out_valid_a", out_valid_a, 1'b1);
        check("out_valid_b", out_valid_b, 1'b1);
        check("out_sum_a", out_sum_a, exp_a);
        check("out_sum_b", out_sum_b, exp_b);
        check("out_beats_a", out_beats_a, 16'(exp_beats));
        check("out_beats_b", out_beats_b, 16'(exp_beats));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_mask  = 4'hF;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("bp_in_ready", in_ready_a, 1'b0);
            check("bp_out_valid", out_valid_a, 1'b1);
            check("bp_out_sum", out_sum_a, exp_a);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        model_clear();
        check("post_hs_ready", in_ready_a, 1'b1);
        check("post_hs_valid", out_valid_a, 1'b0);
        check_running("post_hs_zero");
        $display("result sum_a=%h sum_b=%h beats=%0d hold=%0d", out_sum_a, out_sum_b, out_beats_a, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [L*W-1:0] d;
        int nb;
        model_clear();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_mask   = 4'hF;
        in_data   = {32'd9, 32'd9, 32'd9, 32'd9};
        out_ready = 1'b0;

        // Reset held two cycles with a valid beat offered.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_in_ready", in_ready_a, 1'b0);
            check("rst_out_valid", out_valid_a, 1'b0);
            check("rst_out_sum", out_sum_a, 40'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("rst_release_ready", in_ready_a, 1'b1);
        check_running("rst_nothing_taken");
        @(negedge clk);
        check("rst_no_result", out_valid_a, 1'b0);

        // Single beat {1,2,3,4}.
        push_beat({32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111, 1'b1);
        collect(0);
        check("single_sum", out_sum_a, 40'd10);
        check("single_beats", out_beats_a, 16'd1);

        // Wrap on the 32-bit instance: eight lanes of all-ones.
        push_beat({4{32'hFFFFFFFF}}, 4'b1111, 1'b0);
        push_beat({4{32'hFFFFFFFF}}, 4'b1111, 1'b1);
        collect(0);
        check("wrap_sum", out_sum_b, 32'hFFFFFFF8);
        check("wrap_beats", out_beats_b, 16'd2);

        // Signed with masked lanes.
        push_beat({32'd99, 32'd99, 32'd3, 32'hFFFFFFFB}, 4'b0011, 1'b0);
        push_beat({32'd0, 32'd0, 32'd0, 32'd1}, 4'b0001, 1'b1);
        collect(5);
        check("signed_sum", out_sum_a, 40'hFFFFFFFFFF);
        check("signed_beats", out_beats_a, 16'd2);

        // Packet straight after backpressure.
        push_beat({32'd0, 32'd0, 32'd0, 32'd7}, 4'b1111, 1'b1);
        collect(0);
        check("after_bp_sum", out_sum_a, 40'd7);

        // Reset mid-packet discards the partial sum.
        for (int i = 0; i < 3; i++) push_beat({4{32'd1}}, 4'b1111, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check("midrst_ready", in_ready_a, 1'b1);
        check_running("midrst_zero");
        push_beat({32'd0, 32'd0, 32'd0, 32'd5}, 4'b1111, 1'b1);
        collect(0);
        check("midrst_sum", out_sum_a, 40'd5);
        check("midrst_beats", out_beats_a, 16'd1);

        // Randomized packets with random masks, gaps and backpressure.
        for (int p = 0; p < 25; p++) begin
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                d = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 4) == 0) d = {4{32'hFFFFFFFF}};
                push_beat(d, 4'($urandom_range(0, 15)), (b == nb - 1) ? 1'b1 : 1'b0);
            end
            collect($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
